bench_bist_ctrl: RTL

- Built-in self-test sequencer for the 32-bit combinational benchmark datapath (bench_comb family, ISCAS85 wrappers).
- Generates pseudo-random input vectors with a Galois LFSR and drives them onto the benchmark inputs.
- Waits a programmable settle time, then compacts each benchmark response into a MISR signature.
- After NUM_PATTERNS vectors, compares the signature against a golden value and reports pass/fail. This is the trojan-detection harness around each benchmark.

---
 rtl/bench_bist_pkg.sv | 35 +++
 rtl/bench_bist_galois.sv | 36 +++
 rtl/bench_bist_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bench_bist_pkg.sv
// Shared types, default constants and the Galois step used by the BIST sequencer.
// The optional abort input is enabled with the BIST_ABORT_EN macro (see bench_bist_ctrl).
package bench_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    COMPARE = 2'd3
  } bist_state_t;

  localparam int          MAX_WIDTH             = 64;
  localparam int          IDX_WIDTH             = $clog2(MAX_WIDTH);
  localparam int          DEFAULT_WIDTH         = 32;
  localparam int          DEFAULT_NUM_PATTERNS  = 1024;
  localparam int          DEFAULT_SETTLE_CYCLES = 2;
  localparam logic [31:0] DEFAULT_LFSR_SEED     = 32'h0000_0001;
  localparam logic [31:0] DEFAULT_LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_MISR_POLY     = 32'h8020_0003;

  // Shift left and fold the polynomial in when the bit leaving the top is set;
  // values are carried in MAX_WIDTH bits and masked back to 'width'.
  function automatic logic [MAX_WIDTH-1:0] galois_step(
    input logic [MAX_WIDTH-1:0] r,
    input logic [MAX_WIDTH-1:0] poly,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] mask;
    logic                 msb;
    mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    msb  = r[IDX_WIDTH'(width - 1)];
    galois_step = ((r << 1) ^ (msb ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/bench_bist_galois.sv
// Galois shift register with synchronous load, step enable and XOR data input.
// Serves both as the pattern LFSR (data tied to zero) and the response MISR.
module bist_galois_reg
  import bench_bist_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'(DEFAULT_LFSR_POLY),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] next_value;

  always_comb begin
    next_value = WIDTH'(galois_step(MAX_WIDTH'(value), MAX_WIDTH'(POLY), WIDTH)) ^ data;
  end

  // A load (run start) takes priority over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= RESET_VALUE;
    end else if (load) begin
      value <= load_value;
    end else if (enable) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/bench_bist_ctrl.sv
// BIST sequencer: LFSR patterns into the benchmark, MISR over its responses, golden compare.
// Define BIST_ABORT_EN to add an 'abort' input that cancels a run in SETTLE or CAPTURE.
module bench_bist_ctrl
  import bench_bist_pkg::*;
#(
  parameter int               WIDTH         = DEFAULT_WIDTH,
  parameter int               NUM_PATTERNS  = DEFAULT_NUM_PATTERNS,
  parameter int               SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter logic [WIDTH-1:0] LFSR_SEED     = WIDTH'(DEFAULT_LFSR_SEED),
  parameter logic [WIDTH-1:0] LFSR_POLY     = WIDTH'(DEFAULT_LFSR_POLY),
  parameter logic [WIDTH-1:0] MISR_POLY     = WIDTH'(DEFAULT_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef BIST_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] golden_sig,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      pattern_cnt
);

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("bench_bist_ctrl: LFSR_SEED must be nonzero");
  end
  if (NUM_PATTERNS < 1 || NUM_PATTERNS > 65535) begin : g_bad_num
    $error("bench_bist_ctrl: NUM_PATTERNS must be in 1..65535");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("bench_bist_ctrl: SETTLE_CYCLES must be at least 1");
  end
  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("bench_bist_ctrl: WIDTH out of supported range");
  end

  localparam int            SW           = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [15:0]   LAST_PATTERN = 16'(NUM_PATTERNS - 1);
  localparam logic [15:0]   PATTERN_MAX  = 16'(NUM_PATTERNS);

  bist_state_t   state;
  bist_state_t   next_state;
  logic [SW-1:0] settle_cnt;
  logic          start_run;
  logic          capture_en;
  logic          compare_en;
  logic          abort_hit;

`ifdef BIST_ABORT_EN
  assign abort_hit = abort && (state == SETTLE || state == CAPTURE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // An abort wins over the normal SETTLE/CAPTURE progression and suppresses the capture.
  always_comb begin
    next_state = state;
    start_run  = 1'b0;
    capture_en = 1'b0;
    compare_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_run  = 1'b1;
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (abort_hit) begin
          next_state = IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort_hit) begin
          next_state = IDLE;
        end else begin
          capture_en = 1'b1;
          next_state = (pattern_cnt == LAST_PATTERN) ? COMPARE : SETTLE;
        end
      end
      COMPARE: begin
        compare_en = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (start_run || capture_en) begin
      settle_cnt <= '0;
    end else if (state == SETTLE && !abort_hit && settle_cnt != SETTLE_LAST) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_cnt <= '0;
    end else if (start_run) begin
      pattern_cnt <= '0;
    end else if (capture_en && pattern_cnt != PATTERN_MAX) begin
      pattern_cnt <= pattern_cnt + 16'd1;
    end
  end

  // pass is cleared at start and on abort so a cancelled run never reports success.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      done <= compare_en;
      if (start_run || abort_hit) begin
        pass <= 1'b0;
      end else if (compare_en) begin
        pass <= (signature == golden_sig);
      end
    end
  end

  assign busy = (state != IDLE);

  bist_galois_reg #(
    .WIDTH       (WIDTH),
    .POLY        (LFSR_POLY),
    .RESET_VALUE (LFSR_SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_run),
    .load_value (LFSR_SEED),
    .enable     (capture_en),
    .data       ('0),
    .value      (dut_in)
  );

  bist_galois_reg #(
    .WIDTH       (WIDTH),
    .POLY        (MISR_POLY),
    .RESET_VALUE ('0)
  ) u_misr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_run),
    .load_value ('0),
    .enable     (capture_en),
    .data       (dut_out),
    .value      (signature)
  );

endmodule
